// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between three byte sources, the arbiter and one UART transmitter.
// master = source/transmitter side, slave = arbiter side.
interface uart_tx_arbiter_if;
    logic [2:0]  src_req;
    logic [23:0] src_data;
    logic [2:0]  src_valid;
    logic [2:0]  src_last;
    logic [2:0]  src_ready;
    logic [2:0]  grant;
    logic        uart_start;
    logic [7:0]  uart_data;
    logic        uart_ready;
    logic        abort;

    modport master (
        output src_req, src_data, src_valid, src_last, uart_ready,
        input  src_ready, grant, uart_start, uart_data, abort
    );

    modport slave (
        input  src_req, src_data, src_valid, src_last, uart_ready,
        output src_ready, grant, uart_start, uart_data, abort
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter feeding three byte sources into a single UART transmitter.
// Optional header byte per packet enabled by defining UART_ARB_HEADER_EN.
module uart_tx_arbiter #(
    parameter int          TIMEOUT = 1023,
    parameter logic [7:0]  HDR_TAG = 8'hA0
) (
    input  logic               clk,
    input  logic               rst,
    uart_tx_arbiter_if.slave   bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        FETCH,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         grant_q, grant_d;
    logic [1:0]         owner_q, owner_d;
    logic [1:0]         last_owner_q, last_owner_d;
    logic               last_q, last_d;
    logic               uart_start_q, uart_start_d;
    logic [7:0]         uart_data_q, uart_data_d;
    logic               abort_q, abort_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cnt_inc;
    logic [2:0]         src_ready_c;

    logic [7:0]         src_byte [3];
    logic               sel_valid;
    logic               sel_last;
    logic [7:0]         sel_byte;

    logic [1:0]         rr_base;
    logic [2:0]         rr_idx;
    logic [1:0]         pick_id;
    logic               pick_ok;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_src_byte
            assign src_byte[gi] = bus.src_data[8*gi +: 8];
        end
    endgenerate

    assign sel_valid = bus.src_valid[owner_q];
    assign sel_last  = bus.src_last[owner_q];
    assign sel_byte  = src_byte[owner_q];
    assign cnt_inc   = cnt_q + 1'b1;

    // Search order starts one past the previous owner so every requester gets a turn.
    always_comb begin
        rr_base = (last_owner_q == 2'd2) ? 2'd0 : last_owner_q + 2'd1;
        rr_idx  = 3'd0;
        pick_ok = 1'b0;
        pick_id = 2'd0;
        for (int k = 0; k < 3; k++) begin
            rr_idx = {1'b0, rr_base} + 3'(k);
            if (rr_idx >= 3'd3) begin
                rr_idx = rr_idx - 3'd3;
            end
            if (!pick_ok && bus.src_req[rr_idx[1:0]]) begin
                pick_ok = 1'b1;
                pick_id = rr_idx[1:0];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        last_d       = last_q;
        uart_start_d = 1'b0;
        uart_data_d  = uart_data_q;
        abort_d      = 1'b0;
        cnt_d        = '0;
        src_ready_c  = 3'b000;

        case (state_q)
            IDLE: begin
                if (pick_ok && bus.uart_ready) begin
                    grant_d = 3'b001 << pick_id;
                    owner_d = pick_id;
`ifdef UART_ARB_HEADER_EN
                    state_d = HDR;
`else
                    state_d = FETCH;
`endif
                end
            end

            // Start pulse for the header lands in the first WAIT_BUSY cycle.
            HDR: begin
                uart_data_d  = {HDR_TAG[7:2], owner_q};
                uart_start_d = 1'b1;
                last_d       = 1'b0;
                state_d      = WAIT_BUSY;
            end

            FETCH: begin
                src_ready_c = grant_q;
                if (sel_valid) begin
                    uart_data_d  = sel_byte;
                    uart_start_d = 1'b1;
                    last_d       = sel_last;
                    state_d      = START;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(TIMEOUT)) begin
                        abort_d      = 1'b1;
                        grant_d      = 3'b000;
                        last_owner_d = owner_q;
                        state_d      = IDLE;
                    end
                end
            end

            START: begin
                state_d = WAIT_BUSY;
            end

            // The transmitter keeps uart_ready high one cycle past start; wait for the drop.
            WAIT_BUSY: begin
                if (!bus.uart_ready) begin
                    state_d = WAIT_DONE;
                end
            end

            WAIT_DONE: begin
                if (bus.uart_ready) begin
                    if (last_q) begin
                        grant_d      = 3'b000;
                        last_owner_d = owner_q;
                        state_d      = IDLE;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                grant_d = 3'b000;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= 3'b000;
            owner_q      <= 2'd0;
            last_owner_q <= 2'd2;
            last_q       <= 1'b0;
            uart_start_q <= 1'b0;
            uart_data_q  <= 8'h00;
            abort_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            last_q       <= last_d;
            uart_start_q <= uart_start_d;
            uart_data_q  <= uart_data_d;
            abort_q      <= abort_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus.src_ready  = src_ready_c;
    assign bus.grant      = grant_q;
    assign bus.uart_start = uart_start_q;
    assign bus.uart_data  = uart_data_q;
    assign bus.abort      = abort_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: byte-queue source models, a busy-for-N-cycles UART model,
// and a monitor that logs every uart_start byte, grant change and abort.
module tb_uart_tx_arbiter;
    localparam int TO   = 16;
    localparam int BUSY = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if bus ();

    uart_tx_arbiter #(.TIMEOUT(TO), .HDR_TAG(8'hA0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // UART model: ready stays high one cycle after start, then low for BUSY cycles.
    logic uart_ready_m = 1'b1;
    int   ucnt = 0;
    assign bus.uart_ready = uart_ready_m;
    always @(posedge clk) begin
        if (ucnt > 0) begin
            ucnt         <= ucnt - 1;
            uart_ready_m <= (ucnt == 1);
        end else if (bus.uart_start) begin
            ucnt <= BUSY + 1;
        end
    end

    // Source models: per-source byte FIFO {last, data}, presented on the falling edge.
    logic [8:0]  sbuf [3][16];
    int          shead [3];
    int          stail [3];
    logic [2:0]  pend = 3'b000;
    logic [2:0]  src_req_m = 3'b000;
    logic [2:0]  src_valid_m = 3'b000;
    logic [2:0]  src_last_m = 3'b000;
    logic [23:0] src_data_m = 24'h0;
    assign bus.src_req   = src_req_m;
    assign bus.src_valid = src_valid_m;
    assign bus.src_last  = src_last_m;
    assign bus.src_data  = src_data_m;

    initial begin
        for (int i = 0; i < 3; i++) begin
            shead[i] = 0;
            stail[i] = 0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) shead[i] = 0;
            else if (pend[i]) shead[i] = shead[i] + 1;
            src_valid_m[i]      = !rst && (shead[i] != stail[i]);
            src_data_m[8*i +: 8] = sbuf[i][shead[i] % 16][7:0];
            src_last_m[i]       = sbuf[i][shead[i] % 16][8];
            pend[i]             = src_valid_m[i] && bus.src_ready[i];
        end
    end

    // Monitor
    logic [7:0] start_log [32];
    logic [2:0] grant_log [16];
    int         start_cnt = 0;
    int         grant_cnt = 0;
    int         abort_cnt = 0;
    int         abort_run = 0;
    int         rdy_run   = 0;
    int         ready_run = 0;
    int         gap_viol  = 0;
    logic [2:0] prev_grant = 3'b000;

    always @(negedge clk) begin
        ready_run = bus.uart_ready ? ready_run + 1 : 0;
        if (rst) begin
            start_cnt = 0; grant_cnt = 0; abort_cnt = 0; abort_run = 0;
            rdy_run = 0; gap_viol = 0; prev_grant = 3'b000;
        end else begin
            if (bus.uart_start) begin
                $display("[%0t] uart_start data=%02h grant=%b", $time, bus.uart_data, bus.grant);
                start_log[start_cnt % 32] = bus.uart_data;
                start_cnt++;
                if (ready_run < 3) gap_viol++;
            end
            if (bus.abort) begin
                abort_cnt++;
                abort_run = rdy_run;
            end
            rdy_run = (bus.src_ready != 3'b000) ? rdy_run + 1 : 0;
            if (bus.grant != prev_grant && bus.grant != 3'b000) begin
                grant_log[grant_cnt % 16] = bus.grant;
                grant_cnt++;
            end
            prev_grant = bus.grant;
        end
    end

    logic [7:0] exp_log [32];
    int         exp_n = 0;

    task automatic add_exp(input logic [7:0] b);
        exp_log[exp_n] = b;
        exp_n++;
    endtask

    task automatic add_hdr(input logic [1:0] id);
`ifdef UART_ARB_HEADER_EN
        add_exp({6'b101000, id});
`else
        exp_n = exp_n + 0;
`endif
    endtask

    task automatic push(input int i, input logic last, input logic [7:0] b);
        sbuf[i][stail[i] % 16] = {last, b};
        stail[i] = stail[i] + 1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        src_req_m = 3'b000;
        for (int i = 0; i < 3; i++) stail[i] = 0;
        exp_n = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_starts(input string tag, input int n, input int budget);
        int t = 0;
        while (start_cnt < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        check(tag, 32'(start_cnt >= n), 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int t = 0;
        while (bus.grant != 3'b000 && t < budget) begin
            @(negedge clk);
            t++;
        end
        check(tag, {29'd0, bus.grant}, 32'd0);
    endtask

    task automatic cmp_starts(input string tag);
        check({tag, "_count"}, start_cnt, exp_n);
        for (int k = 0; k < exp_n; k++) check({tag, "_data"}, {24'd0, start_log[k]}, {24'd0, exp_log[k]});
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_grant",     {29'd0, bus.grant},     32'd0);
        check("rst_start",     {31'd0, bus.uart_start}, 32'd0);
        check("rst_data",      {24'd0, bus.uart_data},  32'd0);
        check("rst_abort",     {31'd0, bus.abort},      32'd0);
        check("rst_src_ready", {29'd0, bus.src_ready},  32'd0);

        // Three-byte packet from source 0
        do_reset();
        push(0, 1'b0, 8'h11); push(0, 1'b0, 8'h22); push(0, 1'b1, 8'h33);
        add_hdr(2'd0); add_exp(8'h11); add_exp(8'h22); add_exp(8'h33);
        src_req_m = 3'b001;
        wait_starts("t1_wait", exp_n, 400);
        wait_idle("t1_idle", 100);
        src_req_m = 3'b000;
        cmp_starts("t1");
        check("t1_grant_cnt", grant_cnt, 32'd1);
        check("t1_grant0", {29'd0, grant_log[0]}, 32'h1);
        check("t1_gap", gap_viol, 32'd0);

        // Round robin with all sources requesting
        do_reset();
        push(0, 1'b1, 8'hA1); push(0, 1'b1, 8'hA4);
        push(1, 1'b1, 8'hB2); push(2, 1'b1, 8'hC3);
        add_hdr(2'd0); add_exp(8'hA1); add_hdr(2'd1); add_exp(8'hB2);
        add_hdr(2'd2); add_exp(8'hC3); add_hdr(2'd0); add_exp(8'hA4);
        src_req_m = 3'b111;
        wait_starts("t2_wait", exp_n, 800);
        src_req_m = 3'b000;
        wait_idle("t2_idle", 100);
        cmp_starts("t2");
        check("t2_grant_cnt", grant_cnt, 32'd4);
        check("t2_grant0", {29'd0, grant_log[0]}, 32'h1);
        check("t2_grant1", {29'd0, grant_log[1]}, 32'h2);
        check("t2_grant2", {29'd0, grant_log[2]}, 32'h4);
        check("t2_grant3", {29'd0, grant_log[3]}, 32'h1);
        check("t2_abort_cnt", abort_cnt, 32'd0);
        check("t2_gap", gap_viol, 32'd0);

        // Source 1 stalls mid-packet; timeout abort, then source 2
        do_reset();
        push(1, 1'b0, 8'h55); push(2, 1'b1, 8'h66);
        add_hdr(2'd1); add_exp(8'h55); add_hdr(2'd2); add_exp(8'h66);
        src_req_m = 3'b110;
        wait_starts("t3_wait", exp_n, 800);
        src_req_m = 3'b000;
        wait_idle("t3_idle", 100);
        cmp_starts("t3");
        check("t3_abort_cnt", abort_cnt, 32'd1);
        check("t3_abort_delay", abort_run, TO);
        check("t3_grant_cnt", grant_cnt, 32'd2);
        check("t3_grant0", {29'd0, grant_log[0]}, 32'h2);
        check("t3_grant1", {29'd0, grant_log[1]}, 32'h4);
        check("t3_gap", gap_viol, 32'd0);

`ifdef UART_ARB_HEADER_EN
        // Header byte carries the source id
        do_reset();
        push(2, 1'b1, 8'h5C);
        exp_n = 0; add_exp(8'hA2); add_exp(8'h5C);
        src_req_m = 3'b100;
        wait_starts("t4_wait", exp_n, 300);
        src_req_m = 3'b000;
        wait_idle("t4_idle", 100);
        cmp_starts("t4");
`endif

        // Reset in WAIT_DONE of a four-byte packet
        do_reset();
        push(0, 1'b0, 8'h01); push(0, 1'b0, 8'h02); push(0, 1'b0, 8'h03); push(0, 1'b1, 8'h04);
        add_hdr(2'd0); add_exp(8'h01); add_exp(8'h02);
        src_req_m = 3'b001;
        wait_starts("t5_wait", exp_n, 400);
        begin
            int t = 0;
            while (bus.uart_ready && t < 50) begin
                @(negedge clk);
                t++;
            end
            check("t5_busy_seen", {31'd0, bus.uart_ready}, 32'd0);
        end
        repeat (4) @(negedge clk);
        check("t5_pre_data", {24'd0, bus.uart_data}, 32'h02);
        rst       = 1'b1;
        src_req_m = 3'b000;
        stail[0]  = 0;
        @(negedge clk);
        check("t5_rst_grant",     {29'd0, bus.grant},      32'd0);
        check("t5_rst_start",     {31'd0, bus.uart_start}, 32'd0);
        check("t5_rst_data",      {24'd0, bus.uart_data},  32'd0);
        check("t5_rst_abort",     {31'd0, bus.abort},      32'd0);
        check("t5_rst_src_ready", {29'd0, bus.src_ready},  32'd0);
        rst = 1'b0;
        repeat (80) @(negedge clk);
        check("t5_quiet_starts", start_cnt, 32'd0);
        check("t5_quiet_grant", {29'd0, bus.grant}, 32'd0);
        exp_n = 0;
        push(0, 1'b1, 8'h77);
        add_hdr(2'd0); add_exp(8'h77);
        src_req_m = 3'b001;
        wait_starts("t5_new_wait", exp_n, 300);
        src_req_m = 3'b000;
        wait_idle("t5_new_idle", 100);
        cmp_starts("t5_new");
        check("t5_gap", gap_viol, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 1023: maximum idle cycles tolerated mid-packet before abort.
REQ-002 Parameter HDR_TAG, default 8'hA0: upper bits of the header byte (bits [1:0] replaced by source ID).
REQ-003 clk  in  1  single clock, all logic rising-edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 src_req  in  3  per-source packet request, held high until packet ends.
REQ-006 src_data  in  24  byte per source; source i on bits [8i+7:8i].
REQ-007 src_valid  in  3  per-source byte valid.
REQ-008 src_last  in  3  per-source, marks final byte of packet, qualified by src_valid.
REQ-009 src_ready  out  3  per-source byte accept; transfer when src_valid[i] and src_ready[i] are both high.
REQ-010 grant  out  3  one-hot current owner; 0 when idle.
REQ-011 uart_start  out  1  one-cycle start pulse to the UART transmitter.
REQ-012 uart_data  out  8  byte to the transmitter, stable from the uart_start pulse until the next load.
REQ-013 uart_ready  in  1  transmitter idle flag; it stays high for one cycle after uart_start before dropping.
REQ-014 abort  out  1  one-cycle pulse on timeout abort.

Function
REQ-015 States SHALL be IDLE, HDR, FETCH, START, WAIT_BUSY and WAIT_DONE; all outputs registered except src_ready.
REQ-016 IDLE: when any src_req is high and uart_ready=1, select a source round-robin, set grant one-hot, and go to HDR or FETCH per REQ-029/030.
REQ-017 Round-robin search SHALL start at (last_owner+1) mod 3; last_owner resets to 2, so source 0 wins first.
REQ-018 src_req is sampled only in IDLE; a request arriving mid-packet waits, and dropping src_req mid-packet is ignored.
REQ-019 FETCH: src_ready[g]=1 combinationally, other bits 0; on transfer, latch byte and src_last[g], then go to START.
REQ-020 START: drive uart_start=1 for exactly one cycle with uart_data=latched byte, then go to WAIT_BUSY.
REQ-021 WAIT_BUSY: wait for uart_ready=0, then go to WAIT_DONE; uart_ready=1 on the cycle after start SHALL NOT end the byte.
REQ-022 WAIT_DONE: on uart_ready=1, if latched last=1 then clear grant, update last_owner and go to IDLE; else go to FETCH.
REQ-023 Minimum gap: the next uart_start SHALL occur no earlier than 2 cycles after uart_ready returns high.
REQ-024 Timeout counter (clog2(TIMEOUT+1) bits) SHALL clear on FETCH entry and on every transfer, and increment each FETCH cycle without src_valid[g].
REQ-025 When the counter reaches TIMEOUT: pulse abort, clear grant, update last_owner and go to IDLE; no UART byte is sent for the missing data.
REQ-026 A single-byte packet (src_last with first byte) SHALL send exactly one data byte.
REQ-027 Packet length is unbounded; no byte counter limits it.

Reset
REQ-028 On rst=1 at a clock edge: state=IDLE, grant=0, uart_start=0, uart_data=8'h00, abort=0, src_ready=0, last_owner=2, timeout counter=0; rst mid-packet SHALL abandon the packet without a further uart_start.

Configuration
REQ-029 With macro UART_ARB_HEADER_EN defined, the grant SHALL go to HDR; HDR loads uart_data={HDR_TAG[7:2],id[1:0]}, pulses uart_start, and then follows WAIT_BUSY/WAIT_DONE before FETCH.
REQ-030 Without UART_ARB_HEADER_EN, the HDR state and HDR_TAG are unused, and the grant goes directly to FETCH.

Verification
REQ-031 Reset then src_req=3'b001 with 3 bytes 8'h11,8'h22,8'h33 (last on 8'h33), UART model busy 20 cycles per byte -> exactly 3 uart_start pulses with data 11,22,33; grant 001 then 000.
REQ-032 src_req=3'b111 held, each source sends 1 byte -> grant order 001,010,100, then 001 again.
REQ-033 Source 1 is granted and stalls src_valid after its first byte -> abort pulses TIMEOUT cycles into FETCH, grant clears, and source 2 is granted next.
REQ-034 UART model holds uart_ready=1 for one cycle after start, then 0 -> no second uart_start until uart_ready rises again.
REQ-035 UART_ARB_HEADER_EN defined, source 2 sends 8'h5C -> uart_data sequence A2, 5C.
REQ-036 rst asserted during WAIT_DONE of a 4-byte packet -> all outputs at reset values the next cycle, and no further uart_start until a new request arrives.
